// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM bank: per-channel configuration
// record and its reset value.
package pwm_pkg;

  localparam int PWM_CW = 32;

  typedef struct packed {
    logic [PWM_CW-1:0] duty;
    logic [PWM_CW-1:0] phase;
    logic              polarity;
  } pwm_chan_cfg_t;

  localparam pwm_chan_cfg_t CHAN_CFG_RESET = '{duty: '0, phase: '0, polarity: 1'b0};

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: shadow/active configuration pair, phase-wrapped compare
// against the shared counter, and the registered output.
module pwm_channel
  import pwm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              commit,
  input  logic              we,
  input  logic [PWM_CW-1:0] wr_duty,
  input  logic [PWM_CW-1:0] wr_phase,
  input  logic              wr_polarity,
  input  logic [PWM_CW-1:0] counter,
  input  logic [PWM_CW-1:0] period,
  output logic              pwm,
  output logic              pending
);

  // Two guard bits keep counter + signed phase and the wrap correction exact.
  localparam int SW = PWM_CW + 2;

  pwm_chan_cfg_t shadow;
  pwm_chan_cfg_t active;

  logic signed [SW-1:0] s_raw;
  logic signed [SW-1:0] s_wrap;
  logic signed [SW-1:0] p_ext;
  logic signed [SW-1:0] d_ext;
  logic                 level;

  always_comb begin
    p_ext = $signed({2'b00, period});
    d_ext = $signed({2'b00, active.duty});
    s_raw = $signed({2'b00, counter}) + $signed({{2{active.phase[PWM_CW-1]}}, active.phase});
    if (s_raw[SW-1]) begin
      s_wrap = s_raw + p_ext;
    end else if (s_raw >= p_ext) begin
      s_wrap = s_raw - p_ext;
    end else begin
      s_wrap = s_raw;
    end
    level = (s_wrap < d_ext);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= CHAN_CFG_RESET;
      active <= CHAN_CFG_RESET;
      pwm    <= 1'b0;
    end else begin
      // Commit copies the pre-write shadow, so a same-cycle write waits a period.
      if (commit) begin
        active <= shadow;
      end
      if (we) begin
        shadow <= '{duty: wr_duty, phase: wr_phase, polarity: wr_polarity};
      end
      pwm <= enable ? (level ^ active.polarity) : active.polarity;
    end
  end

  assign pending = (shadow != active);

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator: shared period counter, period shadow/active
// pair, atomic commit at the period boundary, and the channel array.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int COUNTER_WIDTH = PWM_CW,
  parameter int NUM_CHANNELS  = 4
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             enable,
  input  logic                                             cfg_period_we,
  input  logic [COUNTER_WIDTH-1:0]                         cfg_period,
  input  logic                                             cfg_chan_we,
  input  logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] cfg_chan,
  input  logic [COUNTER_WIDTH-1:0]                         cfg_duty,
  input  logic [COUNTER_WIDTH-1:0]                         cfg_phase,
  input  logic                                             cfg_polarity,
  output logic [NUM_CHANNELS-1:0]                          pwm,
  output logic [COUNTER_WIDTH-1:0]                         counter,
  output logic                                             period_end,
  output logic                                             cfg_pending
);

  localparam int CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [COUNTER_WIDTH-1:0] period_sh;
  logic [COUNTER_WIDTH-1:0] period_act;
  logic                     boundary;
  logic                     commit;
  logic [NUM_CHANNELS-1:0]  chan_pending;

  // Periods below 2 collapse to a single count, so every enabled cycle ends one.
  assign boundary = enable &&
                    ((period_act < COUNTER_WIDTH'(2)) ||
                     (counter == (period_act - COUNTER_WIDTH'(1))));
  assign commit   = boundary || !enable;

  always_ff @(posedge clk) begin
    if (rst) begin
      counter    <= '0;
      period_sh  <= '0;
      period_act <= '0;
    end else begin
      if (!enable || boundary) begin
        counter <= '0;
      end else begin
        counter <= counter + COUNTER_WIDTH'(1);
      end
      if (commit) begin
        period_act <= period_sh;
      end
      if (cfg_period_we) begin
        period_sh <= cfg_period;
      end
    end
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    pwm_channel u_chan (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .commit      (commit),
      .we          (cfg_chan_we && (cfg_chan == CHAN_W'(i))),
      .wr_duty     (cfg_duty),
      .wr_phase    (cfg_phase),
      .wr_polarity (cfg_polarity),
      .counter     (counter),
      .period      (period_act),
      .pwm         (pwm[i]),
      .pending     (chan_pending[i])
    );
  end

  assign period_end  = boundary;
  assign cfg_pending = (period_sh != period_act) || (|chan_pending);

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: directed scenarios plus randomized
// configuration traffic, compared every cycle against a behavioural model.
module tb_pwm_bank;

  localparam int NC = 4;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        cfg_period_we;
  logic [31:0] cfg_period;
  logic        cfg_chan_we;
  logic [1:0]  cfg_chan;
  logic [31:0] cfg_duty;
  logic [31:0] cfg_phase;
  logic        cfg_polarity;
  logic [3:0]  pwm;
  logic [31:0] counter;
  logic        period_end;
  logic        cfg_pending;

  int checks = 0;
  int failures = 0;

  // Behavioural model: committed/shadow configuration, count, expected outputs.
  int unsigned m_cnt, m_per, s_per;
  longint      a_duty[NC], s_duty[NC];
  int          a_ph[NC], s_ph[NC];
  bit          a_pol[NC], s_pol[NC];
  logic [3:0]  m_pwm;

  pwm_bank #(.COUNTER_WIDTH(32), .NUM_CHANNELS(NC)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_period_we(cfg_period_we), .cfg_period(cfg_period),
    .cfg_chan_we(cfg_chan_we), .cfg_chan(cfg_chan),
    .cfg_duty(cfg_duty), .cfg_phase(cfg_phase), .cfg_polarity(cfg_polarity),
    .pwm(pwm), .counter(counter), .period_end(period_end), .cfg_pending(cfg_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit model_pending();
    bit p;
    p = (s_per != m_per);
    for (int i = 0; i < NC; i++)
      if (s_duty[i] != a_duty[i] || s_ph[i] != a_ph[i] || s_pol[i] != a_pol[i]) p = 1'b1;
    return p;
  endfunction

  task automatic check_all();
    bit exp_pe;
    exp_pe = enable && (m_per < 2 || m_cnt == m_per - 1);
    chk("counter", longint'(counter), longint'(m_cnt));
    chk("pwm", longint'(pwm), longint'(m_pwm));
    chk("period_end", longint'(period_end), longint'(exp_pe));
    chk("cfg_pending", longint'(cfg_pending), longint'(model_pending()));
  endtask

  // Advance one clock with the currently driven inputs, then update and check the model.
  task automatic tick();
    bit          bnd, cmt;
    logic [3:0]  npwm;
    int unsigned ncnt;
    longint      s;
    bnd = enable && (m_per < 2 || m_cnt == m_per - 1);
    cmt = bnd || !enable;
    for (int i = 0; i < NC; i++) begin
      if (enable) begin
        s = longint'(m_cnt) + longint'(a_ph[i]);
        if (m_per != 0) s = ((s % longint'(m_per)) + longint'(m_per)) % longint'(m_per);
        npwm[i] = (s < a_duty[i]) ^ a_pol[i];
      end else begin
        npwm[i] = a_pol[i];
      end
    end
    if (!enable || m_per < 2) ncnt = 0;
    else ncnt = (m_cnt + 1) % m_per;
    @(posedge clk);
    #1;
    if (rst) begin
      m_cnt = 0; m_per = 0; s_per = 0; m_pwm = 4'b0000;
      for (int i = 0; i < NC; i++) begin
        a_duty[i] = 0; s_duty[i] = 0; a_ph[i] = 0; s_ph[i] = 0; a_pol[i] = 0; s_pol[i] = 0;
      end
    end else begin
      m_cnt = ncnt;
      m_pwm = npwm;
      if (cmt) begin
        m_per = s_per;
        for (int i = 0; i < NC; i++) begin
          a_duty[i] = s_duty[i]; a_ph[i] = s_ph[i]; a_pol[i] = s_pol[i];
        end
      end
      if (cfg_period_we) s_per = cfg_period;
      if (cfg_chan_we) begin
        s_duty[cfg_chan] = longint'(cfg_duty);
        s_ph[cfg_chan]   = int'(cfg_phase);
        s_pol[cfg_chan]  = cfg_polarity;
      end
    end
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wr_period(input int unsigned p);
    cfg_period_we = 1'b1; cfg_period = p;
    tick();
    cfg_period_we = 1'b0;
  endtask

  task automatic wr_chan(input int c, input int unsigned d, input int ph, input bit pol);
    cfg_chan_we = 1'b1; cfg_chan = 2'(c); cfg_duty = d; cfg_phase = 32'(ph); cfg_polarity = pol;
    tick();
    cfg_chan_we = 1'b0;
  endtask

  task automatic wait_count(input int unsigned v);
    int n;
    n = 0;
    while (counter !== v && n < 4100) begin
      tick();
      n++;
    end
    if (counter !== v) begin
      checks++;
      failures++;
      $error("FAIL wait_count got=%0d exp=%0d", counter, v);
    end
  endtask

  task automatic measure(input int ch, input int n, output int hi, output int pe);
    hi = 0;
    pe = 0;
    repeat (n) begin
      tick();
      hi += int'(pwm[ch]);
      pe += int'(period_end);
    end
  endtask

  initial begin
    int hi, pe;
    rst = 1'b1; enable = 1'b0;
    cfg_period_we = 1'b0; cfg_period = 32'd0;
    cfg_chan_we = 1'b0; cfg_chan = 2'd0; cfg_duty = 32'd0; cfg_phase = 32'd0; cfg_polarity = 1'b0;
    m_cnt = 0; m_per = 0; s_per = 0; m_pwm = 4'b0000;
    for (int i = 0; i < NC; i++) begin
      a_duty[i] = 0; s_duty[i] = 0; a_ph[i] = 0; s_ph[i] = 0; a_pol[i] = 0; s_pol[i] = 0;
    end
    run(2);
    chk("reset_pwm", longint'(pwm), 0);
    chk("reset_pending", longint'(cfg_pending), 0);
    rst = 1'b0;

    // Basic 50% waveform at P=1000
    wr_period(1000);
    wr_chan(0, 500, 0, 1'b0);
    run(1);
    enable = 1'b1;
    measure(0, 1000, hi, pe);
    chk("ch0_high_count", hi, 500);
    chk("period_end_count", pe, 1);

    // Positive and negative phase offsets
    wr_chan(1, 500, 10, 1'b0);
    wr_chan(2, 500, -10, 1'b0);
    chk("pending_after_write", longint'(cfg_pending), 1);
    run(1000);
    wait_count(0);
    measure(1, 1000, hi, pe);
    chk("ch1_high_count", hi, 500);
    wait_count(0);
    measure(2, 1000, hi, pe);
    chk("ch2_high_count", hi, 500);

    // Duty extremes and polarity inversion
    wr_chan(0, 0, 0, 1'b0);
    wr_chan(3, 1000, 0, 1'b0);
    run(1000);
    wait_count(0);
    measure(3, 1000, hi, pe);
    chk("duty_full_high", hi, 1000);
    wr_chan(0, 0, 0, 1'b1);
    wr_chan(3, 1000, 0, 1'b1);
    run(1000);
    wait_count(0);
    measure(0, 1000, hi, pe);
    chk("duty0_inverted", hi, 1000);
    wait_count(0);
    measure(3, 1000, hi, pe);
    chk("duty_full_inverted", hi, 0);

    // Mid-period reconfiguration waits for the boundary
    wait_count(300);
    wr_period(2000);
    wr_chan(0, 750, 1000, 1'b0);
    chk("pending_mid_period", longint'(cfg_pending), 1);
    chk("old_period_kept", longint'(counter), 302);
    wait_count(0);
    measure(0, 2000, hi, pe);
    chk("new_wave_high", hi, 750);
    chk("new_period_end", pe, 1);

    // Write coincident with period_end applies one period later
    wait_count(1999);
    wr_chan(1, 100, 0, 1'b0);
    chk("pending_coincident", longint'(cfg_pending), 1);
    measure(1, 2000, hi, pe);
    chk("coincident_old_used", hi, 500);
    measure(1, 2000, hi, pe);
    chk("coincident_new_used", hi, 100);

    // Reset mid-period discards shadows
    wr_chan(2, 77, 0, 1'b1);
    wait_count(400);
    rst = 1'b1;
    tick();
    chk("rst_counter", longint'(counter), 0);
    chk("rst_pwm", longint'(pwm), 0);
    chk("rst_pending", longint'(cfg_pending), 0);
    rst = 1'b0;
    run(5);

    // Degenerate periods: P=1 and P=0
    enable = 1'b0;
    wr_period(1);
    wr_chan(0, 1, 0, 1'b0);
    run(1);
    enable = 1'b1;
    measure(0, 6, hi, pe);
    chk("p1_pe_every_cycle", pe, 6);
    chk("p1_always_active", hi, 6);
    wr_period(0);
    run(6);

    // Randomized configuration traffic with short periods
    enable = 1'b0;
    wr_period(12);
    run(1);
    enable = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      cfg_chan_we   = ($urandom_range(7) == 0);
      cfg_chan      = 2'($urandom_range(3));
      cfg_duty      = 32'($urandom_range(24));
      cfg_phase     = 32'($urandom_range(14) - 7);
      cfg_polarity  = 1'($urandom_range(1));
      cfg_period_we = ($urandom_range(19) == 0);
      cfg_period    = 32'($urandom_range(20, 8));
      if ($urandom_range(29) == 0) enable = ~enable;
      tick();
    end
    cfg_chan_we = 1'b0;
    cfg_period_we = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
